game_flow_ctrl: RTL and testbench

Game-flow state machine that consumes the level-type start/pause request produced by the front-panel start toggler. It tracks IDLE/RUN/PAUSE/OVER and generates the gated game-step strobe that paces all game logic. It also keeps a saturating elapsed-seconds count for the score display. It sits between the key-input front end and the game core and display blocks.

---
 rtl/game_pkg.sv | 12 +
 rtl/tick_prescaler.sv | 38 +++
 rtl/game_flow_ctrl.sv | 148 ++++++++++++++
 tb/tb_game_flow_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-flow state encoding, used by the flow controller,
// the game core and the display blocks.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } game_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-DIV counter with a registered one-cycle strobe.
// Ports: clk, rst_n (async low), en (advance), clr (sync clear), strobe.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic strobe
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap = (cnt == LAST);

    // A disabled cycle holds the count, so a count parked on LAST
    // fires its strobe on the first enabled cycle that follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= en && wrap;
            if (en) begin
                cnt <= wrap ? '0 : cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow FSM (IDLE/RUN/PAUSE/OVER): paced game_tick strobe and a
// saturating elapsed-seconds count. Ports: clk, rst_n, start_lvl, hit,
// state, game_tick, elapsed_sec, over_flag.
// Option: GAME_FLOW_HIT_LATCH_EN turns a hit during PAUSE into OVER on resume.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV      = 1_000_000,
    parameter int TICKS_PER_SEC = 50,
    parameter int MAX_SEC       = 999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_lvl,
    input  logic       hit,
    output logic [1:0] state,
    output logic       game_tick,
    output logic [9:0] elapsed_sec,
    output logic       over_flag
);

    generate
        if (MAX_SEC < 0 || MAX_SEC > 1023) begin : g_max_sec_chk
            $error("MAX_SEC must fit in 10 bits");
        end
    endgenerate

    localparam logic [9:0] SEC_LAST = 10'(MAX_SEC);

    game_state_e state_q, state_d;
    logic        lvl_q;
    logic        armed_q;
    logic        rise, fall;
    logic        pend;
    logic        clr_game, run_en, over_d;
    logic        over_q;
    logic        sec_stb;
    logic [9:0]  elapsed_q;

    // armed_q blocks a rise on the first cycle after reset, so a level
    // already high at release needs a fresh low-to-high transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            lvl_q   <= start_lvl;
            armed_q <= 1'b1;
        end
    end

    assign rise = armed_q & start_lvl & ~lvl_q;
    assign fall = ~start_lvl & lvl_q;

`ifdef GAME_FLOW_HIT_LATCH_EN
    logic pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
        end else if (state_q != ST_PAUSE || state_d != ST_PAUSE) begin
            pend_q <= 1'b0;
        end else if (hit) begin
            pend_q <= 1'b1;
        end
    end

    assign pend = pend_q | hit;
`else
    assign pend = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (hit)       state_d = ST_OVER;
                else if (fall) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (rise) state_d = pend ? ST_OVER : ST_RUN;
            end
            ST_OVER: begin
                if (rise) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters advance on cycles whose next state is RUN: leaving RUN
    // parks the prescaler, and re-entering lets a parked tick fire at once.
    always_comb begin
        run_en   = (state_d == ST_RUN);
        over_d   = (state_d == ST_OVER);
        clr_game = run_en &&
                   (state_q == ST_IDLE || state_q == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            over_q <= 1'b0;
        end else begin
            over_q <= over_d;
        end
    end

    tick_prescaler #(.DIV(TICK_DIV)) u_tick_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (run_en),
        .clr    (clr_game),
        .strobe (game_tick)
    );

    tick_prescaler #(.DIV(TICKS_PER_SEC)) u_sec_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (game_tick),
        .clr    (clr_game),
        .strobe (sec_stb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elapsed_q <= '0;
        end else if (clr_game) begin
            elapsed_q <= '0;
        end else if (sec_stb && elapsed_q != SEC_LAST) begin
            elapsed_q <= elapsed_q + 10'd1;
        end
    end

    assign state       = state_q;
    assign elapsed_sec = elapsed_q;
    assign over_flag   = over_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl
// (TICK_DIV=4, TICKS_PER_SEC=3, MAX_SEC=5).
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_lvl = 1'b1;
    logic       hit = 1'b0;
    logic [1:0] state;
    logic       game_tick;
    logic [9:0] elapsed_sec;
    logic       over_flag;

    int vectors = 0;
    int miscompares = 0;

    game_flow_ctrl #(
        .TICK_DIV      (4),
        .TICKS_PER_SEC (3),
        .MAX_SEC       (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_lvl   (start_lvl),
        .hit         (hit),
        .state       (state),
        .game_tick   (game_tick),
        .elapsed_sec (elapsed_sec),
        .over_flag   (over_flag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st,
                           input logic tk, input int el, input logic ov);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".tick"}, 32'(game_tick), 32'(tk));
        chk({tag, ".elapsed"}, 32'(elapsed_sec), el);
        chk({tag, ".over"}, 32'(over_flag), 32'(ov));
    endtask

    int exp_el;
    logic exp_ov;
    logic [1:0] exp_st;

    initial begin
        // reset with start_lvl already high
        #2 rst_n = 1'b0;
        #1 chk_all("rst", 2'b00, 1'b0, 0, 1'b0);
        step(); step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_all("idle_hold", 2'b00, 1'b0, 0, 1'b0);
        end

        // fresh game: entry edge then tick every 4 cycles
        start_lvl = 1'b0;
        step();
        start_lvl = 1'b1;
        step();
        chk_all("enter_run", 2'b01, 1'b0, 0, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            step();
            exp_el = (i >= 2) ? (i - 2) / 12 : 0;
            chk("run1.tick", 32'(game_tick), 32'(i % 4 == 0));
            chk("run1.elapsed", 32'(elapsed_sec), exp_el);
        end

        // pause with prescaler at 2, hold 50 cycles
        start_lvl = 1'b0;
        step();
        chk_all("pause", 2'b10, 1'b0, 2, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step();
            chk("pause.tick", 32'(game_tick), 0);
            chk("pause.elapsed", 32'(elapsed_sec), 2);
        end

        // resume: held prescaler gives a tick on the 2nd RUN cycle
        start_lvl = 1'b1;
        step();
        chk_all("resume", 2'b01, 1'b0, 2, 1'b0);
        for (int j = 1; j <= 75; j++) begin
            step();
            exp_el = 2 + ((j >= 7) ? (j - 7) / 12 + 1 : 0);
            if (exp_el > 5) exp_el = 5;
            chk("run2.tick", 32'(game_tick), 32'(j % 4 == 1));
            chk("run2.elapsed", 32'(elapsed_sec), exp_el);
        end

        // hit and fall together: hit wins
        hit = 1'b1;
        start_lvl = 1'b0;
        step();
        hit = 1'b0;
        chk_all("hit_fall", 2'b11, 1'b0, 5, 1'b1);
        step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        step();
        chk_all("over_hit", 2'b11, 1'b0, 5, 1'b1);

        // new game from OVER clears counters
        start_lvl = 1'b1;
        step();
        chk_all("new_game", 2'b01, 1'b0, 0, 1'b0);

        // pause while prescaler sits at 3
        step(); step(); step();
        start_lvl = 1'b0;
        step();
        chk_all("pause_at3", 2'b10, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("pause3.tick", 32'(game_tick), 0);
        end
        start_lvl = 1'b1;
        step();
        chk_all("resume_at3", 2'b01, 1'b1, 0, 1'b0);

        // hit while paused, then resume
        start_lvl = 1'b0;
        step();
        chk_all("pause_hit0", 2'b10, 1'b0, 0, 1'b0);
        hit = 1'b1;
        step();
        hit = 1'b0;
        chk("pause_hit.state", 32'(state), 32'(2'b10));
        step();
        start_lvl = 1'b1;
        step();
`ifdef GAME_FLOW_HIT_LATCH_EN
        exp_st = 2'b11;
        exp_ov = 1'b1;
`else
        exp_st = 2'b01;
        exp_ov = 1'b0;
`endif
        chk("pause_hit.resume", 32'(state), 32'(exp_st));
        chk("pause_hit.over", 32'(over_flag), 32'(exp_ov));

        // get to OVER either way, then start a fresh game
        hit = 1'b1;
        step();
        hit = 1'b0;
        chk("to_over.state", 32'(state), 32'(2'b11));
        start_lvl = 1'b0;
        step();
        start_lvl = 1'b1;
        step();
        chk_all("game3", 2'b01, 1'b0, 0, 1'b0);
        for (int i = 1; i <= 16; i++) step();
        chk_all("pre_rst", 2'b01, 1'b1, 1, 1'b0);

        // asynchronous reset mid-RUN
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 2'b00, 1'b0, 0, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("post_rst", 2'b00, 1'b0, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
